rx_timing_ctrl: RTL and testbench

UART receive timing controller that sits directly upstream of the 9-bit receive shift register. It synchronizes the raw serial line, detects and validates the start bit, and times the mid-bit points. At each mid-bit point it pulses `shift_strobe` for the 8 data bits and the stop bit. After the frame it checks the stop bit from the shift register, then either pulses `load_buffer` to the RX data buffer or flags a framing error.

---
 rtl/rx_pkg.sv | 15 +
 rtl/rx_bit_timer.sv | 35 +++
 rtl/rx_timing_ctrl.sv | 117 +++++++++++
 tb/tb_rx_timing_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the UART receive timing path.
package rx_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10;
  localparam int RX_FRAME_BITS        = 9;   // 8 data bits + stop bit

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Up-counter with synchronous clear, enable and a terminal-count flag; wraps to 0 after MAX_COUNT.
module rx_bit_timer #(
  parameter int MAX_COUNT = 9,
  parameter int W         = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_d, count_q;

  assign tc    = (count_q == W'(MAX_COUNT));
  assign count = count_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/rx_timing_ctrl.sv
// UART RX timing controller: synchronizes the line, validates the start bit and
// strobes the downstream 9-bit shift register at each mid-bit point.
module rx_timing_ctrl
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(RX_FRAME_BITS + 1);

  rx_state_t state_d, state_q;
  logic [BW-1:0] bit_cnt_d, bit_cnt_q;
  logic          ferr_d, ferr_q;
  logic          meta_q, sync_q, sync_prev_q;
  logic [TW-1:0] timer_cnt;
  logic          timer_tc;
  logic          timer_clr;
  logic          start_edge;

  // Two-flop synchronizer plus one delay stage for falling-edge detection; all idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      sync_prev_q <= 1'b1;
    end else begin
      meta_q      <= serial_in;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
    end
  end

  assign start_edge = sync_prev_q & ~sync_q;
  assign timer_clr  = (state_d != state_q);

  rx_bit_timer #(
    .MAX_COUNT(CLKS_PER_BIT - 1),
    .W        (TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (1'b1),
    .count(timer_cnt),
    .tc   (timer_tc)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ferr_d       = ferr_q;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        // A line already back high at mid-start-bit is treated as noise, not an error.
        if (timer_cnt == TW'(HALF_BIT - 1)) begin
          state_d   = sync_q ? IDLE : RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (timer_tc) begin
          shift_strobe = 1'b1;
          bit_cnt_d    = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(RX_FRAME_BITS - 1)) state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        if (stop_bit) begin
          state_d = LOAD;
        end else begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      LOAD: begin
        load_buffer = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ferr_q    <= ferr_d;
    end
  end

  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rx_timing_ctrl.sv
// Directed self-checking bench for rx_timing_ctrl with a behavioural 9-bit shift register model.
module tb_rx_timing_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic stop_bit;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  int checks   = 0;
  int failures = 0;

  rx_timing_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .stop_bit     (stop_bit),
    .shift_strobe (shift_strobe),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Downstream shift register and RX buffer: LSB-first data ends in sr[7:0], stop in sr[8].
  logic [8:0] sr = '0;
  logic [7:0] rx_data = '0;
  assign stop_bit = sr[8];
  always @(posedge clk) begin
    if (shift_strobe) sr <= {serial_in, sr[8:1]};
    if (load_buffer)  rx_data <= sr[7:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: times are relative to E, the edge at which rx_busy first rises.
  int   e_cyc = 0, n_str = 0, n_load = 0, load_t = -1, busy_drop = -1;
  int   tot_str = 0, tot_load = 0, frames = 0, overlap = 0;
  int   str_t [16];
  logic err_at_start = 1'b0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_busy && !busy_prev) begin
      e_cyc        = cyc;
      n_str        = 0;
      n_load       = 0;
      load_t       = -1;
      busy_drop    = -1;
      err_at_start = framing_error;
      frames++;
    end
    if (!rx_busy && busy_prev) busy_drop = cyc - e_cyc;
    if (shift_strobe) begin
      if (n_str < 16) str_t[n_str] = cyc - e_cyc + 1;
      n_str++;
      tot_str++;
    end
    if (load_buffer) begin
      load_t = cyc - e_cyc;
      n_load++;
      tot_load++;
    end
    if (shift_strobe && load_buffer) overlap++;
    busy_prev = rx_busy;
  end

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({shift_strobe, load_buffer, framing_error, rx_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000", {shift_strobe, load_buffer, framing_error, rx_busy});
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rx_busy !== 1'b0 || tot_str !== 0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b strobes=%0d expected busy=0 strobes=0", rx_busy, tot_str);
    end
  endtask

  task automatic test_clean_frame;
    send_frame(8'h41, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (n_str !== 9) begin
      failures++;
      $display("FAIL clean_strobe_count: got %0d expected 9", n_str);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (str_t[i] !== 15 + 10 * i) begin
        failures++;
        $display("FAIL clean_strobe_time[%0d]: got E+%0d expected E+%0d", i, str_t[i], 15 + 10 * i);
      end
    end
    checks++;
    if (n_load !== 1 || load_t !== 96) begin
      failures++;
      $display("FAIL clean_load: got count=%0d at E+%0d expected count=1 at E+96", n_load, load_t);
    end
    checks++;
    if (busy_drop !== 97) begin
      failures++;
      $display("FAIL clean_busy_drop: got E+%0d expected E+97", busy_drop);
    end
    checks++;
    if (framing_error !== 1'b0) begin
      failures++;
      $display("FAIL clean_ferr: got %b expected 0", framing_error);
    end
    checks++;
    if (rx_data !== 8'h41) begin
      failures++;
      $display("FAIL clean_data: got %h expected 41", rx_data);
    end
  endtask

  task automatic test_bad_stop;
    int base_load;
    base_load = tot_load;
    send_frame(8'h41, 1'b0);
    serial_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (n_str !== 9 || tot_load !== base_load) begin
      failures++;
      $display("FAIL badstop_counts: got strobes=%0d loads=%0d expected strobes=9 loads=0", n_str, tot_load - base_load);
    end
    checks++;
    if (framing_error !== 1'b1) begin
      failures++;
      $display("FAIL badstop_ferr: got %b expected 1", framing_error);
    end
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (framing_error !== 1'b1) begin
      failures++;
      $display("FAIL badstop_ferr_sticky: got %b expected 1", framing_error);
    end
    send_frame(8'h5A, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (err_at_start !== 1'b0) begin
      failures++;
      $display("FAIL badstop_ferr_clear_on_start: got %b expected 0", err_at_start);
    end
    checks++;
    if (n_load !== 1 || rx_data !== 8'h5A || framing_error !== 1'b0) begin
      failures++;
      $display("FAIL badstop_next_frame: loads=%0d data=%h ferr=%b expected 1 5a 0", n_load, rx_data, framing_error);
    end
  endtask

  task automatic test_start_glitch;
    int base_str, base_frames;
    base_str    = tot_str;
    base_frames = frames;
    serial_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (frames !== base_frames + 1) begin
      failures++;
      $display("FAIL glitch_start_entered: got %0d starts expected 1", frames - base_frames);
    end
    checks++;
    if (busy_drop !== 5) begin
      failures++;
      $display("FAIL glitch_return_idle: got E+%0d expected E+5", busy_drop);
    end
    checks++;
    if (tot_str !== base_str || framing_error !== 1'b0) begin
      failures++;
      $display("FAIL glitch_no_effect: strobes=%0d ferr=%b expected 0 0", tot_str - base_str, framing_error);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base_str, base_load, budget;
    base_str  = tot_str;
    base_load = tot_load;
    serial_in = 1'b0;
    budget    = 0;
    while (tot_str < base_str + 4 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checks++;
    if (tot_str !== base_str + 4) begin
      failures++;
      $display("FAIL rstmid_reach_4th: got %0d strobes expected 4 within budget", tot_str - base_str);
    end
    rst       = 1'b1;
    serial_in = 1'b1;
    #1;
    checks++;
    if ({shift_strobe, load_buffer, framing_error, rx_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_outputs: got %b expected 0000", {shift_strobe, load_buffer, framing_error, rx_busy});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    checks++;
    if (tot_str !== base_str + 4 || tot_load !== base_load || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: strobes=%0d loads=%0d busy=%b expected 4 0 0", tot_str - base_str, tot_load - base_load, rx_busy);
    end
    send_frame(8'hC3, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (n_str !== 9 || load_t !== 96 || rx_data !== 8'hC3) begin
      failures++;
      $display("FAIL rstmid_recover: strobes=%0d load=E+%0d data=%h expected 9 E+96 c3", n_str, load_t, rx_data);
    end
  endtask

  task automatic test_back_to_back;
    int base_str, base_load, base_frames;
    base_str    = tot_str;
    base_load   = tot_load;
    base_frames = frames;
    send_frame(8'hA5, 1'b1);
    checks++;
    if (rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL b2b_first_data: got %h expected a5", rx_data);
    end
    send_frame(8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (frames !== base_frames + 2) begin
      failures++;
      $display("FAIL b2b_frames: got %0d expected 2", frames - base_frames);
    end
    checks++;
    if (tot_str !== base_str + 18 || tot_load !== base_load + 2) begin
      failures++;
      $display("FAIL b2b_counts: strobes=%0d loads=%0d expected 18 2", tot_str - base_str, tot_load - base_load);
    end
    checks++;
    if (str_t[8] !== 95 || load_t !== 96 || rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_second_frame: last_strobe=E+%0d load=E+%0d data=%h expected E+95 E+96 3c", str_t[8], load_t, rx_data);
    end
  endtask

  task automatic test_break;
    int base_str, base_load, base_frames;
    base_str    = tot_str;
    base_load   = tot_load;
    base_frames = frames;
    serial_in   = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (frames !== base_frames + 1 || tot_str !== base_str + 9 || tot_load !== base_load) begin
      failures++;
      $display("FAIL break_one_frame: frames=%0d strobes=%0d loads=%0d expected 1 9 0", frames - base_frames, tot_str - base_str, tot_load - base_load);
    end
    checks++;
    if (framing_error !== 1'b1 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL break_state: ferr=%b busy=%b expected 1 0", framing_error, rx_busy);
    end
    serial_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (tot_str !== base_str + 9 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL break_release: strobes=%0d busy=%b expected 9 0", tot_str - base_str, rx_busy);
    end
    send_frame(8'h7E, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (err_at_start !== 1'b0 || tot_load !== base_load + 1 || rx_data !== 8'h7E || framing_error !== 1'b0) begin
      failures++;
      $display("FAIL break_next_frame: ferr_at_start=%b loads=%0d data=%h ferr=%b expected 0 1 7e 0", err_at_start, tot_load - base_load, rx_data, framing_error);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_bad_stop();
    test_start_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    test_break();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL strobe_load_overlap: got %0d cycles expected 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
